usb_uart_tx_arb: RTL
====================

USB_UART_TX_ARB -- requirements
Module: usb_uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, number of byte-stream requesters (2..4).
REQ-002 SHALL have parameter MAX_BURST, default 64, maximum bytes per grant (1..255).
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 16, stall cycles before forced release (1..255).
REQ-004 SHALL have clk_48mhz  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have src_data  input  8*NUM_SRC  byte per requester, source i at bits [8i+7:8i].
REQ-007 SHALL have src_valid  input  NUM_SRC  per-requester byte valid.
REQ-008 SHALL have src_last  input  NUM_SRC  per-requester end-of-message flag, qualified by src_valid.
REQ-009 SHALL have src_ready  output  NUM_SRC  per-requester byte accept.
REQ-010 SHALL have uart_in_data  output  8  byte toward usb_uart uart_in_data.
REQ-011 SHALL have uart_in_valid  output  1  byte valid toward usb_uart.
REQ-012 SHALL have uart_in_ready  input  1  accept from usb_uart.
REQ-013 SHALL have grant_id  output  2  index of current owner, 0 when idle.
REQ-014 SHALL have busy  output  1  high while state is GRANT.

Function
REQ-015 SHALL implement states IDLE and GRANT.
REQ-016 IDLE: if any src_valid high, SHALL grant the first requester at or after rr_ptr (wrapping), enter GRANT next cycle; no byte transferred in the arbitration cycle.
REQ-017 In GRANT, src_ready[grant_id] SHALL equal (!uart_in_valid | uart_in_ready); all other src_ready bits SHALL be 0; in IDLE all src_ready SHALL be 0.
REQ-018 Accepted byte (src_valid & src_ready of owner) SHALL be registered into uart_in_data/uart_in_valid on the same edge: latency one cycle.
REQ-019 uart_in_valid SHALL stay high and uart_in_data stable until uart_in_ready high; simultaneous drain and refill SHALL sustain one byte per cycle.
REQ-020 burst_cnt (8-bit) SHALL clear on grant and increment per accepted byte.
REQ-021 Grant SHALL release (GRANT->IDLE) on the edge accepting a byte with src_last high, or the byte making burst_cnt equal MAX_BURST; whichever occurs first; simultaneous conditions release once.
REQ-022 On release rr_ptr SHALL become (grant_id+1) mod NUM_SRC.
REQ-023 Release SHALL NOT drop a byte still held in the output register; it drains normally while IDLE arbitrates.
REQ-024 src_valid of non-owners SHALL have no effect during GRANT.
REQ-025 Owner deasserting src_valid mid-message SHALL keep the grant (subject to REQ-033).

Reset
REQ-026 reset_n low SHALL asynchronously force: state IDLE, rr_ptr 0, burst_cnt 0, idle counter 0.
REQ-027 During and after reset: uart_in_valid 0, uart_in_data 8'h00, src_ready all 0, grant_id 0, busy 0.
REQ-028 Reset mid-burst SHALL discard the held byte; first post-reset grant SHALL start at requester 0.
REQ-029 Reset deassertion is synchronised externally; block SHALL arbitrate from the first edge after release.

Configuration
REQ-030 Macro USB_TX_ARB_TIMEOUT_EN SHALL control the idle-timeout release.
REQ-031 Defined: 8-bit idle counter SHALL count GRANT cycles with owner src_valid low, clear on any owner byte accepted.
REQ-032 Defined: counter reaching IDLE_TIMEOUT SHALL release grant as in REQ-021/022.
REQ-033 Undefined: no idle counter; grant held until src_last or MAX_BURST only.

Verification
REQ-034 Single source 0 sends 3 bytes 0x41,0x42,0x43(last), uart_in_ready=1 -> uart_in_data 0x41..0x43 on consecutive cycles, first one cycle after first accept; busy falls after 0x43 accepted.
REQ-035 Sources 0,1,2 all valid, 2-byte messages each -> output order src0,src0,src1,src1,src2,src2; grant_id 0,1,2.
REQ-036 MAX_BURST=4, source 1 streams 10 bytes no last while source 2 valid -> after 4 bytes grant moves to 2, then returns to 1.
REQ-037 uart_in_ready held low 5 cycles with byte 0x55 held -> uart_in_valid stays 1, data stays 0x55, owner src_ready 0, no byte lost or duplicated.
REQ-038 With USB_TX_ARB_TIMEOUT_EN, IDLE_TIMEOUT=16, owner stalls 16 cycles, source 2 valid -> grant moves to 2; without macro, grant stays.
REQ-039 reset_n pulsed low mid-burst with byte held -> uart_in_valid 0 immediately; post-reset, sources 1,2 valid -> grant_id 1 first.

Source files
------------

// File: rtl/usb_uart_tx_arb.sv
// usb_uart_tx_arb: round-robin arbiter that merges NUM_SRC byte streams into one usb_uart TX port.
// Optional idle-timeout release of a stalled owner is compiled in with `define USB_TX_ARB_TIMEOUT_EN.
module usb_uart_tx_arb #(
  parameter int NUM_SRC      = 3,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                 clk_48mhz,
  input  logic                 reset_n,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [7:0]           uart_in_data,
  output logic                 uart_in_valid,
  input  logic                 uart_in_ready,
  output logic [1:0]           grant_id,
  output logic                 busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;

  logic [7:0] src_byte [NUM_SRC];
  logic       owner_valid;
  logic       owner_last;
  logic       room;
  logic       accept;
  logic       burst_hit;
  logic       timeout_hit;
  logic       any_req;
  logic [1:0] pick;
  logic [1:0] owner_next_ptr;
  logic [8:0] burst_inc;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src_byte
    assign src_byte[g] = src_data[8*g +: 8];
  end

  // First requester at or after ptr, scanning upward and wrapping at NUM_SRC.
  function automatic logic [1:0] rr_pick(input logic [NUM_SRC-1:0] req, input logic [1:0] ptr);
    logic [1:0] sel;
    logic [1:0] idx;
    logic       found;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = 2'((int'(ptr) + k) % NUM_SRC);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign any_req        = |src_valid;
  assign pick           = rr_pick(src_valid, rr_ptr_q);
  assign owner_valid    = src_valid[owner_q];
  assign owner_last     = src_last[owner_q];
  // The output register can take a new byte when empty or being drained this same cycle.
  assign room           = !out_valid_q || uart_in_ready;
  assign accept         = (state_q == ST_GRANT) && owner_valid && room;
  assign burst_inc      = {1'b0, burst_cnt_q} + 9'd1;
  assign burst_hit      = (burst_inc == 9'(MAX_BURST));
  assign owner_next_ptr = (owner_q == 2'(NUM_SRC - 1)) ? 2'd0 : owner_q + 2'd1;

`ifdef USB_TX_ARB_TIMEOUT_EN
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic [8:0] idle_inc;

  assign idle_inc = {1'b0, idle_cnt_q} + 9'd1;

  // Counts grant cycles in which the owner has nothing to offer; any accepted byte restarts it.
  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    timeout_hit = 1'b0;
    if (state_q != ST_GRANT) begin
      idle_cnt_d = '0;
    end else if (accept) begin
      idle_cnt_d = '0;
    end else if (!owner_valid) begin
      idle_cnt_d  = idle_inc[7:0];
      timeout_hit = (idle_inc == 9'(IDLE_TIMEOUT));
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    src_ready   = '0;

    if (out_valid_q && uart_in_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d     = pick;
          burst_cnt_d = '0;
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        src_ready[owner_q] = room;
        if (accept) begin
          out_data_d  = src_byte[owner_q];
          out_valid_d = 1'b1;
          burst_cnt_d = burst_inc[7:0];
        end
        // A held byte is never dropped on release: it keeps draining while IDLE re-arbitrates.
        if ((accept && (owner_last || burst_hit)) || timeout_hit) begin
          state_d  = ST_IDLE;
          rr_ptr_d = owner_next_ptr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy          = (state_q == ST_GRANT);
  assign grant_id      = busy ? owner_q : 2'd0;
  assign uart_in_data  = out_data_q;
  assign uart_in_valid = out_valid_q;

endmodule
